c2c_mem_responder: RTL and testbench

C2C_MEM_RESPONDER -- requirements
Module: c2c_mem_responder

---
 rtl/c2c_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_c2c_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2c_mem_responder.sv
// Single-port memory responder serving instruction-read, data-read and data-write
// requests one at a time, with fixed priority and a programmable ack latency.
module c2c_mem_responder #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                instr_re,
    input  logic [XLEN/8-1:0]   instr_sel,
    input  logic [XLEN-1:0]     instr_addr,
    output logic                instr_ack,
    output logic [31:0]         instr_data,

    input  logic                dr_re,
    input  logic [XLEN/8-1:0]   dr_sel,
    input  logic [XLEN-1:0]     dr_addr,
    output logic                dr_ack,
    output logic [XLEN-1:0]     dr_data,

    input  logic                dw_we,
    input  logic [XLEN/8-1:0]   dw_sel,
    input  logic [XLEN-1:0]     dw_addr,
    input  logic [XLEN-1:0]     dw_data,
    output logic                dw_ack,

    output logic                err
);

    localparam int unsigned SELW = XLEN / 8;
    localparam int unsigned OFFW = $clog2(SELW);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CNTW = 4;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [XLEN-1:0] DEPTH_W  = XLEN'(DEPTH);

    // Elaboration-time guard on illegal parameter combinations
    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("c2c_mem_responder: XLEN must be 32 or 64");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("c2c_mem_responder: DEPTH must be a power of two");
        end
        if (LATENCY > 15) begin : g_bad_latency
            $error("c2c_mem_responder: LATENCY must be 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PORT_NONE  = 2'd0,
        PORT_INSTR = 2'd1,
        PORT_DR    = 2'd2,
        PORT_DW    = 2'd3
    } port_t;

    state_t              state, state_nxt;
    logic [CNTW-1:0]     cnt, cnt_nxt;
    port_t               port_q, port_nxt;
    logic [XLEN-1:0]     addr_q, addr_nxt;
    logic [XLEN-1:0]     wdata_q, wdata_nxt;
    logic [SELW-1:0]     sel_q, sel_nxt;

    logic [XLEN-1:0]     mem [DEPTH];

    logic [IDXW-1:0]     word_idx;
    logic                oor;
    logic                commit;
    logic                instr_half;
    logic [XLEN-1:0]     rd_word;
    logic [31:0]         instr_word;

    // Next-state: arbitration and request latching happen only in IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        port_nxt  = port_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        sel_nxt   = sel_q;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (dw_we) begin
                    port_nxt  = PORT_DW;
                    addr_nxt  = dw_addr;
                    sel_nxt   = dw_sel;
                    wdata_nxt = dw_data;
                end else if (dr_re) begin
                    port_nxt  = PORT_DR;
                    addr_nxt  = dr_addr;
                    sel_nxt   = dr_sel;
                    wdata_nxt = '0;
                end else if (instr_re) begin
                    port_nxt  = PORT_INSTR;
                    addr_nxt  = instr_addr;
                    sel_nxt   = instr_sel;
                    wdata_nxt = '0;
                end
                if (dw_we || dr_re || instr_re) begin
                    state_nxt = (LATENCY > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ACK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            ACK: begin
                state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
                port_nxt  = PORT_NONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            port_q  <= PORT_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            port_q  <= port_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            sel_q   <= sel_nxt;
        end
    end

    // Byte-offset bits drop out of the index; anything past DEPTH is out of range
    assign word_idx   = addr_q[OFFW +: IDXW];
    assign oor        = (addr_q >> OFFW) >= DEPTH_W;
    assign commit     = (state == ACK);
    assign rd_word    = mem[word_idx];
    assign instr_half = (XLEN == 64) ? addr_q[2] : 1'b0;
    assign instr_word = instr_half ? rd_word[XLEN-1 -: 32] : rd_word[31:0];

    // Responses register on the edge that closes ACK, so they appear during GAP
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_ack  <= 1'b0;
            instr_data <= '0;
            dr_ack     <= 1'b0;
            dr_data    <= '0;
            dw_ack     <= 1'b0;
            err        <= 1'b0;
        end else begin
            instr_ack  <= commit && (port_q == PORT_INSTR);
            dr_ack     <= commit && (port_q == PORT_DR);
            dw_ack     <= commit && (port_q == PORT_DW);
            instr_data <= (commit && (port_q == PORT_INSTR) && !oor) ? instr_word : '0;
            dr_data    <= (commit && (port_q == PORT_DR) && !oor) ? rd_word : '0;
            err        <= err | (commit && oor);
        end
    end

    // Storage is not reset; writes land on the same edge as dw_ack
    always_ff @(posedge clk) begin
        if (!reset && commit && (port_q == PORT_DW) && !oor) begin
            for (int unsigned b = 0; b < SELW; b++) begin
                if (sel_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_c2c_mem_responder.sv
// Directed plus randomized checks of c2c_mem_responder against an array-based memory model.
module tb_c2c_mem_responder;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    localparam int P_INSTR = 0;
    localparam int P_DR    = 1;
    localparam int P_DW    = 2;

    logic              clk;
    logic              reset;
    logic              instr_re;
    logic [7:0]        instr_sel;
    logic [63:0]       instr_addr;
    logic              instr_ack;
    logic [31:0]       instr_data;
    logic              dr_re;
    logic [7:0]        dr_sel;
    logic [63:0]       dr_addr;
    logic              dr_ack;
    logic [63:0]       dr_data;
    logic              dw_we;
    logic [7:0]        dw_sel;
    logic [63:0]       dw_addr;
    logic [63:0]       dw_data;
    logic              dw_ack;
    logic              err;

    int                n_total = 0;
    int                n_pass  = 0;

    logic [63:0]       mem_m [DEPTH];
    logic              err_m;
    logic [63:0]       pool [8];

    c2c_mem_responder #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_re   (instr_re),
        .instr_sel  (instr_sel),
        .instr_addr (instr_addr),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .dr_re      (dr_re),
        .dr_sel     (dr_sel),
        .dr_addr    (dr_addr),
        .dr_ack     (dr_ack),
        .dr_data    (dr_data),
        .dw_we      (dw_we),
        .dw_sel     (dw_sel),
        .dw_addr    (dw_addr),
        .dw_data    (dw_data),
        .dw_ack     (dw_ack),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic is_oor(input logic [63:0] a);
        return (a >> 3) >= 64'(DEPTH);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'(a[12:3]);
    endfunction

    // Model result of a transaction applied in request order
    task automatic model_apply(input int port, input logic [63:0] a, input logic [7:0] sel,
                               input logic [63:0] d, output logic [63:0] exp_data);
        exp_data = '0;
        if (is_oor(a)) begin
            err_m = 1'b1;
        end else if (port == P_DW) begin
            for (int b = 0; b < 8; b++)
                if (sel[b]) mem_m[widx(a)][8*b +: 8] = d[8*b +: 8];
        end else if (port == P_DR) begin
            exp_data = mem_m[widx(a)];
        end else begin
            exp_data = a[2] ? {32'h0, mem_m[widx(a)][63:32]} : {32'h0, mem_m[widx(a)][31:0]};
        end
    endtask

    task automatic do_req(input int port, input logic [63:0] a, input logic [7:0] sel,
                          input logic [63:0] d, input string tag, output logic [63:0] obs);
        int          n;
        bit          got;
        logic [63:0] exp_data;
        logic [2:0]  exp_acks;
        @(negedge clk);
        case (port)
            P_DW:    begin dw_we = 1'b1; dw_addr = a; dw_sel = sel; dw_data = d; end
            P_DR:    begin dr_re = 1'b1; dr_addr = a; dr_sel = sel; end
            default: begin instr_re = 1'b1; instr_addr = a; instr_sel = sel; end
        endcase
        @(posedge clk);
        #1;
        dw_we = 1'b0; dr_re = 1'b0; instr_re = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (dw_ack || dr_ack || instr_ack) got = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LATENCY + 1));
        model_apply(port, a, sel, d, exp_data);
        exp_acks = 3'b001 << port;
        chk({tag, "_acks"}, 64'({dw_ack, dr_ack, instr_ack}), 64'(exp_acks));
        chk({tag, "_dr_data"}, dr_data, (port == P_DR) ? exp_data : 64'h0);
        chk({tag, "_instr_data"}, 64'(instr_data), (port == P_INSTR) ? exp_data : 64'h0);
        chk({tag, "_err"}, 64'(err), 64'(err_m));
        obs = (port == P_DR) ? dr_data : 64'(instr_data);
        @(posedge clk);
        #1;
        chk({tag, "_gap_idle"}, {dr_data[63:3], dw_ack, dr_ack, instr_ack} | 64'(instr_data), 64'h0);
    endtask

    initial begin
        logic [63:0] obs;
        logic [63:0] a;
        logic [63:0] d;
        int          t;
        int          t_dw, t_dr, t_in;
        int          n_ack;
        logic [63:0] exp_data;

        reset = 1'b1;
        instr_re = 1'b0; instr_sel = '0; instr_addr = '0;
        dr_re = 1'b0; dr_sel = '0; dr_addr = '0;
        dw_we = 1'b0; dw_sel = '0; dw_addr = '0; dw_data = '0;
        err_m = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acks", 64'({dw_ack, dr_ack, instr_ack}), 64'h0);
        chk("rst_dr_data", dr_data, 64'h0);
        chk("rst_instr_data", 64'(instr_data), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write then read
        do_req(P_DW, 64'h10, 8'hFF, 64'hDEADBEEF_01234567, "wr10", obs);
        do_req(P_DR, 64'h10, 8'h00, 64'h0, "rd10", obs);
        chk("rd10_const", obs, 64'hDEADBEEF_01234567);

        // Byte mask
        do_req(P_DW, 64'h20, 8'hFF, 64'h11111111_11111111, "wr20a", obs);
        do_req(P_DW, 64'h20, 8'h0F, 64'hAAAAAAAA_AAAAAAAA, "wr20b", obs);
        do_req(P_DR, 64'h20, 8'h01, 64'h0, "rd20", obs);
        chk("rd20_const", obs, 64'h11111111_AAAAAAAA);

        // sel==0 write acks and leaves data alone
        do_req(P_DW, 64'h20, 8'h00, 64'h55555555_55555555, "wr20z", obs);
        do_req(P_DR, 64'h27, 8'hFF, 64'h0, "rd20z", obs);
        chk("rd20z_const", obs, 64'h11111111_AAAAAAAA);

        // Instruction half select
        do_req(P_DW, 64'h0, 8'hFF, 64'h00000013_00100093, "wr0", obs);
        do_req(P_INSTR, 64'h4, 8'hFF, 64'h0, "ins4", obs);
        chk("ins4_const", obs, 64'h00000013);
        do_req(P_INSTR, 64'h0, 8'hFF, 64'h0, "ins0", obs);
        chk("ins0_const", obs, 64'h00100093);

        // Arbitration: all three raised together and held until served
        a = 64'h40;
        d = 64'hCAFEF00D_12345678;
        @(negedge clk);
        dw_we = 1'b1; dw_addr = a; dw_sel = 8'hFF; dw_data = d;
        dr_re = 1'b1; dr_addr = a; dr_sel = 8'hFF;
        instr_re = 1'b1; instr_addr = a | 64'h4; instr_sel = 8'hFF;
        t = 0; t_dw = -1; t_dr = -1; t_in = -1;
        for (int i = 0; i < 40 && (t_in < 0 || t_dr < 0 || t_dw < 0); i++) begin
            @(posedge clk);
            #1;
            t++;
            n_ack = int'(dw_ack) + int'(dr_ack) + int'(instr_ack);
            if (n_ack != 0) chk("arb_single_ack", 64'(n_ack), 64'h1);
            if (dw_ack) begin
                t_dw = t;
                model_apply(P_DW, a, 8'hFF, d, exp_data);
                dw_we = 1'b0;
            end
            if (dr_ack) begin
                t_dr = t;
                model_apply(P_DR, a, 8'hFF, 64'h0, exp_data);
                chk("arb_dr_data", dr_data, exp_data);
                dr_re = 1'b0;
            end
            if (instr_ack) begin
                t_in = t;
                model_apply(P_INSTR, a | 64'h4, 8'hFF, 64'h0, exp_data);
                chk("arb_instr_data", 64'(instr_data), exp_data);
                instr_re = 1'b0;
            end
        end
        dw_we = 1'b0; dr_re = 1'b0; instr_re = 1'b0;
        chk("arb_t_dw", 64'(t_dw), 64'(LATENCY + 2));
        chk("arb_t_dr", 64'(t_dr), 64'(2 * LATENCY + 5));
        chk("arb_t_instr", 64'(t_in), 64'(3 * LATENCY + 8));
        @(posedge clk);
        #1;

        // Out of range read; err stays set across later good accesses
        do_req(P_DR, 64'h2000, 8'hFF, 64'h0, "oor_rd", obs);
        chk("oor_rd_const", obs, 64'h0);
        chk("oor_err_const", 64'(err), 64'h1);
        do_req(P_DR, 64'h10, 8'hFF, 64'h0, "post_oor_rd", obs);
        chk("err_sticky", 64'(err), 64'h1);

        // Reset during WAIT aborts the write
        @(negedge clk);
        dw_we = 1'b1; dw_addr = 64'h10; dw_sel = 8'hFF; dw_data = 64'h0BADC0DE_0BADC0DE;
        @(posedge clk);
        #1;
        dw_we = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        err_m = 1'b0;
        chk("rstw_err", 64'(err), 64'h0);
        chk("rstw_acks", 64'({dw_ack, dr_ack, instr_ack}), 64'h0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n_ack += int'(dw_ack) + int'(dr_ack) + int'(instr_ack);
        end
        chk("rstw_no_ack", 64'(n_ack), 64'h0);
        do_req(P_DR, 64'h10, 8'hFF, 64'h0, "rstw_rd", obs);
        chk("rstw_rd_const", obs, 64'hDEADBEEF_01234567);

        // Randomized traffic over a small address pool plus out-of-range hits
        for (int i = 0; i < 8; i++) begin
            pool[i] = 64'($urandom_range(16, DEPTH - 1)) << 3;
            do_req(P_DW, pool[i], 8'hFF, {$urandom, $urandom}, "rnd_init", obs);
        end
        for (int i = 0; i < 40; i++) begin
            int port;
            port = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                a = 64'(DEPTH * 8) + 64'($urandom_range(0, 100000));
            else
                a = pool[$urandom_range(0, 7)] | 64'($urandom_range(0, 7));
            do_req(port, a, 8'($urandom_range(0, 255)), {$urandom, $urandom}, "rnd", obs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
